// File: rtl/console_pkg.sv
// Shared constants, control codes and FSM state encoding for the VGA console sequencer.
package console_pkg;

  localparam int DEF_NUM_ROWS   = 3;
  localparam int DEF_NUM_COLS   = 10;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [6:0] CODE_LF    = 7'h0A;
  localparam logic [6:0] CODE_CR    = 7'h0D;
  localparam logic [6:0] CODE_BS    = 7'h08;
  localparam logic [6:0] CODE_FF    = 7'h0C;
  localparam logic [6:0] CODE_SPACE = 7'h20;
  localparam logic [7:0] BLANK_CELL = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUT    = 3'd1,
    ST_BS     = 3'd2,
    ST_SCROLL = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

  function automatic logic is_printable(input logic [6:0] code);
    return (code >= CODE_SPACE);
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Small synchronous first-word-fall-through byte FIFO with full/empty flags.
module console_fifo
  import console_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vga_console_ctrl.sv
// Terminal-style sequencer owning the text-buffer write port: put, backspace, scroll, clear.
// Define VGA_CONSOLE_VBLANK_WRITE_EN to restrict buffer writes to blanking intervals.
module vga_console_ctrl
  import console_pkg::*;
#(
  parameter  int NUM_ROWS   = DEF_NUM_ROWS,
  parameter  int NUM_COLS   = DEF_NUM_COLS,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int NUM_CHARS  = NUM_ROWS * NUM_COLS,
  localparam int AW         = $clog2(NUM_CHARS),
  localparam int RW         = $clog2(NUM_ROWS),
  localparam int CW         = $clog2(NUM_COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ch_valid,
  input  logic [7:0]    ch_data,
  output logic          ch_ready,
  input  logic          blank_i,
  output logic [AW-1:0] buf_raddr,
  input  logic [7:0]    buf_rdata,
  output logic [AW-1:0] buf_waddr,
  output logic [7:0]    buf_wdata,
  output logic          buf_we,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          busy
);

  localparam logic [AW-1:0] COLS_A    = AW'(NUM_COLS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_CHARS - 1);
  localparam logic [AW-1:0] SCROLL_HI = AW'(NUM_CHARS - NUM_COLS);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(NUM_COLS - 1);

  state_e        r_state, w_state_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [7:0]    r_char, w_char_nxt;
  logic [7:0]    w_fifo_dout;
  logic [6:0]    w_code;
  logic [CW-1:0] w_wcol;
  logic [AW-1:0] w_cell_addr;
  logic          w_full, w_empty, w_pop, w_wg;

`ifdef VGA_CONSOLE_VBLANK_WRITE_EN
  assign w_wg = blank_i;
`else
  logic w_unused_blank;
  assign w_unused_blank = blank_i;
  assign w_wg = 1'b1;
`endif

  console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (ch_valid),
    .i_data  (ch_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_code   = w_fifo_dout[6:0];
  assign ch_ready = ~w_full | ~rst_n;
  assign busy     = (r_state != ST_IDLE) | ~w_empty;
  assign cur_row  = r_row;
  assign cur_col  = r_col;
  // Backspace erases the cell left of the cursor, so it addresses col-1.
  assign w_wcol      = (r_state == ST_BS) ? (r_col - CW'(1'b1)) : r_col;
  assign w_cell_addr = (AW'(r_row) * COLS_A) + AW'(w_wcol);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_char  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_idx   <= w_idx_nxt;
      r_char  <= w_char_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_idx_nxt   = r_idx;
    w_char_nxt  = r_char;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (is_printable(w_code)) begin
            w_char_nxt  = w_fifo_dout;
            w_state_nxt = ST_PUT;
          end else begin
            case (w_code)
              CODE_LF: begin
                w_col_nxt = '0;
                if (r_row == LAST_ROW) begin
                  w_state_nxt = ST_SCROLL;
                  w_idx_nxt   = '0;
                end else begin
                  w_row_nxt = r_row + RW'(1'b1);
                end
              end
              CODE_CR: w_col_nxt = '0;
              CODE_BS: begin
                if (r_col != '0) w_state_nxt = ST_BS;
                else             w_state_nxt = ST_IDLE;
              end
              CODE_FF: begin
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = '0;
              end
              default: w_state_nxt = ST_IDLE;
            endcase
          end
        end else begin
          w_pop = 1'b0;
        end
      end
      ST_PUT: begin
        if (w_wg) begin
          if (r_col < LAST_COL) begin
            w_col_nxt   = r_col + CW'(1'b1);
            w_state_nxt = ST_IDLE;
          end else begin
            w_col_nxt = '0;
            if (r_row == LAST_ROW) begin
              w_state_nxt = ST_SCROLL;
              w_idx_nxt   = '0;
            end else begin
              w_row_nxt   = r_row + RW'(1'b1);
              w_state_nxt = ST_IDLE;
            end
          end
        end else begin
          w_state_nxt = ST_PUT;
        end
      end
      ST_BS: begin
        if (w_wg) begin
          w_col_nxt   = r_col - CW'(1'b1);
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BS;
        end
      end
      ST_SCROLL, ST_CLEAR: begin
        if (w_wg) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_col_nxt   = '0;
            w_row_nxt   = (r_state == ST_SCROLL) ? LAST_ROW : '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt = r_idx + AW'(1'b1);
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Scroll reads one row ahead of the cell it writes; the last row is filled with blanks.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = r_idx;
    buf_wdata = BLANK_CELL;
    buf_raddr = (r_idx < SCROLL_HI) ? (r_idx + COLS_A) : r_idx;
    case (r_state)
      ST_PUT: begin
        buf_we    = w_wg & rst_n;
        buf_waddr = w_cell_addr;
        buf_wdata = r_char;
      end
      ST_BS: begin
        buf_we    = w_wg & rst_n;
        buf_waddr = w_cell_addr;
      end
      ST_SCROLL: begin
        buf_we    = w_wg & rst_n;
        buf_wdata = (r_idx < SCROLL_HI) ? buf_rdata : BLANK_CELL;
      end
      ST_CLEAR: buf_we = w_wg & rst_n;
      default:  buf_we = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed self-checking bench for vga_console_ctrl with a behavioural text-buffer array.
module tb_vga_console_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = 8'h00;
  logic       ch_ready;
  logic       blank_i = 1'b1;
  logic [4:0] buf_raddr, buf_waddr;
  logic [7:0] buf_rdata, buf_wdata;
  logic       buf_we;
  logic [1:0] cur_row;
  logic [3:0] cur_col;
  logic       busy;

  logic [7:0] mem [32];
  int         we_count = 0;
  int         tests_run = 0;
  int         tests_failed = 0;

  vga_console_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .blank_i(blank_i), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_we(buf_we), .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  assign buf_rdata = mem[buf_raddr];

  always @(posedge clk) begin
    if (buf_we) begin
      mem[buf_waddr] <= buf_wdata;
      we_count <= we_count + 1;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    ch_valid = 1'b1;
    ch_data  = b;
    while (!ch_ready && n < 100) begin cyc(); n++; end
    if (n >= 100) begin
      tests_run++; tests_failed++;
      $display("FAIL push_timeout: byte %h ready stuck at %b, expected 1", b, ch_ready);
    end
    cyc();
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin cyc(); n++; end
    if (n >= 400) begin
      tests_run++; tests_failed++;
      $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic check_cursor(input string name, input logic [1:0] r, input logic [3:0] c);
    tests_run++;
    if (cur_row !== r || cur_col !== c) begin
      tests_failed++;
      $display("FAIL %s_cursor: got (%0d,%0d) expected (%0d,%0d)", name, cur_row, cur_col, r, c);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    cyc(); cyc();
    tests_run++;
    if (buf_we !== 1'b0 || ch_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_outputs: we=%b ready=%b expected we=0 ready=1", buf_we, ch_ready);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (buf_we !== 1'b1 || buf_waddr !== 5'(i) || buf_wdata !== 8'h20) bad++;
      cyc();
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_clear_seq: %0d bad cycles, expected 0", bad);
    end
    tests_run++;
    if (busy !== 1'b0 || buf_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: busy=%b we=%b expected 0 0", busy, buf_we);
    end
    check_cursor("reset", 2'd0, 4'd0);
  endtask

  task automatic test_put();
    push_byte(8'h41);
    tests_run++;
    if (buf_we !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL put_pre: we=%b busy=%b expected 0 1", buf_we, busy);
    end
    cyc();
    tests_run++;
    if (buf_we !== 1'b1 || buf_waddr !== 5'd0 || buf_wdata !== 8'h41) begin
      tests_failed++;
      $display("FAIL put_write: we=%b addr=%0d data=%h expected 1 0 41", buf_we, buf_waddr, buf_wdata);
    end
    push_byte(8'hC2);
    wait_idle("put");
    tests_run++;
    if (mem[0] !== 8'h41 || mem[1] !== 8'hC2) begin
      tests_failed++;
      $display("FAIL put_mem: got %h %h expected 41 c2", mem[0], mem[1]);
    end
    check_cursor("put", 2'd0, 4'd2);
  endtask

  task automatic test_scroll();
    int bad = 0;
    int w0;
    push_byte(8'h0C);
    wait_idle("scroll_ff");
    w0 = we_count;
    for (int i = 0; i < 30; i++) push_byte(8'h30 + 8'(i));
    wait_idle("scroll_fill");
    for (int j = 0; j < 30; j++) begin
      if (j < 20 && mem[j] !== 8'h3A + 8'(j)) bad++;
      if (j >= 20 && mem[j] !== 8'h20) bad++;
    end
    tests_run++;
    if (bad !== 0 || (we_count - w0) !== 60) begin
      tests_failed++;
      $display("FAIL scroll_content: %0d bad cells, %0d writes, expected 0 and 60", bad, we_count - w0);
    end
    check_cursor("scroll_wrap", 2'd2, 4'd0);
    push_byte(8'h4E);
    wait_idle("scroll_31");
    tests_run++;
    if (mem[20] !== 8'h4E || mem[21] !== 8'h20 || mem[19] !== 8'h4D) begin
      tests_failed++;
      $display("FAIL scroll_31st: got %h %h %h expected 4e 20 4d", mem[20], mem[21], mem[19]);
    end
    check_cursor("scroll_31", 2'd2, 4'd1);
  endtask

  task automatic test_ctrl();
    int w0;
    push_byte(8'h0C);
    wait_idle("ctrl_ff");
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h08); push_byte(8'h0D); push_byte(8'h0A);
    wait_idle("ctrl_seq");
    tests_run++;
    if (mem[0] !== 8'h41 || mem[1] !== 8'h20) begin
      tests_failed++;
      $display("FAIL ctrl_bs_mem: got %h %h expected 41 20", mem[0], mem[1]);
    end
    check_cursor("ctrl_crlf", 2'd1, 4'd0);
    w0 = we_count;
    push_byte(8'h01);
    wait_idle("ctrl_unknown");
    tests_run++;
    if (we_count !== w0) begin
      tests_failed++;
      $display("FAIL ctrl_unknown_we: %0d writes expected 0", we_count - w0);
    end
    check_cursor("ctrl_unknown", 2'd1, 4'd0);
    push_byte(8'h0A); push_byte(8'h0A);
    wait_idle("ctrl_lf_scroll");
    tests_run++;
    if (mem[0] !== 8'h20 || (we_count - w0) !== 30) begin
      tests_failed++;
      $display("FAIL ctrl_lf_scroll: mem0=%h writes=%0d expected 20 30", mem[0], we_count - w0);
    end
    check_cursor("ctrl_lf_scroll", 2'd2, 4'd0);
    w0 = we_count;
    push_byte(8'h08);
    wait_idle("ctrl_bs0");
    tests_run++;
    if (we_count !== w0) begin
      tests_failed++;
      $display("FAIL ctrl_bs_col0: %0d writes expected 0", we_count - w0);
    end
    check_cursor("ctrl_bs_col0", 2'd2, 4'd0);
  endtask

`ifdef VGA_CONSOLE_VBLANK_WRITE_EN
  task automatic test_vblank();
    int w0 = we_count;
    blank_i = 1'b0;
    push_byte(8'h58);
    for (int i = 0; i < 5; i++) cyc();
    tests_run++;
    if (we_count !== w0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL vblank_stall: writes=%0d busy=%b expected 0 1", we_count - w0, busy);
    end
    blank_i = 1'b1;
    #1;
    tests_run++;
    if (buf_we !== 1'b1 || buf_waddr !== 5'd20 || buf_wdata !== 8'h58) begin
      tests_failed++;
      $display("FAIL vblank_write: we=%b addr=%0d data=%h expected 1 20 58", buf_we, buf_waddr, buf_wdata);
    end
    cyc();
    check_cursor("vblank", 2'd2, 4'd1);
  endtask
`endif

  task automatic test_fifo_full();
    int bad = 0;
    push_byte(8'h0C);
    cyc();
    ch_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ch_data = 8'h61 + 8'(k);
      if (ch_ready !== (k < 4)) bad++;
      cyc();
    end
    ch_valid = 1'b0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL fifo_ready_seq: %0d bad ready samples expected 0", bad);
    end
    wait_idle("fifo_full");
    tests_run++;
    if (mem[0] !== 8'h61 || mem[3] !== 8'h64 || mem[4] !== 8'h20) begin
      tests_failed++;
      $display("FAIL fifo_drop5: got %h %h %h expected 61 64 20", mem[0], mem[3], mem[4]);
    end
    check_cursor("fifo_full", 2'd0, 4'd4);
  endtask

  task automatic test_reset_mid_scroll();
    int n = 0;
    int bad = 0;
    push_byte(8'h0A); push_byte(8'h0A); push_byte(8'h0A);
    while (!(buf_we === 1'b1 && buf_waddr === 5'd5) && n < 100) begin cyc(); n++; end
    tests_run++;
    if (n >= 100) begin
      tests_failed++;
      $display("FAIL midscroll_reach: waddr=%0d expected 5", buf_waddr);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (buf_we !== 1'b0 || ch_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midscroll_in_reset: we=%b ready=%b expected 0 1", buf_we, ch_ready);
    end
    cyc();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (buf_we !== 1'b1 || buf_waddr !== 5'd0 || buf_wdata !== 8'h20) begin
      tests_failed++;
      $display("FAIL midscroll_restart: we=%b addr=%0d data=%h expected 1 0 20", buf_we, buf_waddr, buf_wdata);
    end
    check_cursor("midscroll", 2'd0, 4'd0);
    wait_idle("midscroll");
    for (int j = 0; j < 30; j++) if (mem[j] !== 8'h20) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL midscroll_clear: %0d non-blank cells expected 0", bad);
    end
  endtask

  initial begin
    for (int j = 0; j < 32; j++) mem[j] = 8'h00;
    test_reset();
    test_put();
    test_scroll();
    test_ctrl();
`ifdef VGA_CONSOLE_VBLANK_WRITE_EN
    test_vblank();
`endif
    test_fifo_full();
    test_reset_mid_scroll();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
